// File: rtl/arith_pkg.sv
// Shared arithmetic-unit types: divider FSM encoding and counter sizing helper.
package arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  // Wide enough to hold the iteration count N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M, restore on borrow.
module div_step
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic [N-1:0] m,
  output logic [N:0]   a_next,
  output logic [N-1:0] q_next
);

  logic [N:0]   a_sh;
  logic [N-1:0] q_sh;
  logic [N:0]   diff;

  always_comb begin
    {a_sh, q_sh} = {a, q} << 1;
    diff         = a_sh - {1'b0, m};
    // diff[N] is the borrow: set means the trial subtraction went negative.
    a_next = diff[N] ? a_sh : diff;
    q_next = q_sh | {{(N-1){1'b0}}, ~diff[N]};
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// N-bit unsigned sequential restoring divider, one quotient bit per clock, start/done handshake.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  div_state_t    state, state_nx;
  logic [N:0]    a_r, a_nx;
  logic [N-1:0]  q_r, q_nx;
  logic [N-1:0]  m_r;
  logic [CW-1:0] cnt;
  logic          dbz_r;
  logic          accept;
  logic          zero_div;

  assign accept   = (state == IDLE) && start;
  assign zero_div = (divisor == '0);

  div_step #(.N(N)) u_step (
    .a      (a_r),
    .q      (q_r),
    .m      (m_r),
    .a_next (a_nx),
    .q_next (q_nx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = zero_div ? DONE : RUN;
      RUN:     if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    quotient    = q_r;
    remainder   = a_r[N-1:0];
    div_by_zero = dbz_r;
  end

  // Divide-by-zero skips RUN and presents the conventional all-ones quotient.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_r   <= '0;
      q_r   <= '0;
      m_r   <= '0;
      cnt   <= '0;
      dbz_r <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        a_r   <= {1'b0, dividend};
        q_r   <= '1;
        dbz_r <= 1'b1;
      end else begin
        a_r   <= '0;
        q_r   <= dividend;
        m_r   <= divisor;
        cnt   <= CW'(N);
        dbz_r <= 1'b0;
      end
    end else if (state == RUN) begin
      a_r <= a_nx;
      q_r <= q_nx;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: N=4 and N=8 instances checked every cycle against a timing/arith model.
module tb_seq_restoring_divider;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       st[2];
  logic [7:0] dd[2], dv[2];
  logic       bsy[2], dn[2], dz[2];
  logic [3:0] q0, r0;
  logic [7:0] q1, r1;

  always #5 clock = ~clock;

  seq_restoring_divider #(.N(4)) dut4 (
    .clock(clock), .reset(reset), .start(st[0]),
    .dividend(dd[0][3:0]), .divisor(dv[0][3:0]),
    .busy(bsy[0]), .done(dn[0]), .quotient(q0), .remainder(r0), .div_by_zero(dz[0])
  );

  seq_restoring_divider #(.N(8)) dut8 (
    .clock(clock), .reset(reset), .start(st[1]),
    .dividend(dd[1]), .divisor(dv[1]),
    .busy(bsy[1]), .done(dn[1]), .quotient(q1), .remainder(r1), .div_by_zero(dz[1])
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int launch[2]  = '{-1000, -1000};
  int done_at[2] = '{-1000, -1000};
  logic [7:0] eq[2] = '{8'h0, 8'h0};
  logic [7:0] er[2] = '{8'h0, 8'h0};
  logic       ez[2] = '{1'b0, 1'b0};

  function automatic logic [7:0] qo(input int k);
    return (k == 0) ? {4'h0, q0} : q1;
  endfunction

  function automatic logic [7:0] ro(input int k);
    return (k == 0) ? {4'h0, r0} : r1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted start at edge e finishes at edge e+N (e for divide-by-zero);
  // starts are only honoured once the previous done cycle has passed.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        launch[k]  = -1000;
        done_at[k] = -1000;
        eq[k] = 8'h0; er[k] = 8'h0; ez[k] = 1'b0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        int w;
        logic [7:0] mask, a, b;
        w    = (k == 0) ? 4 : 8;
        mask = (k == 0) ? 8'h0F : 8'hFF;
        a    = dd[k] & mask;
        b    = dv[k] & mask;
        if (st[k] && cyc > done_at[k] + 1) begin
          launch[k] = cyc;
          if (b == 8'h0) begin
            eq[k] = mask; er[k] = a; ez[k] = 1'b1; done_at[k] = cyc;
          end else begin
            eq[k] = a / b; er[k] = a % b; ez[k] = 1'b0; done_at[k] = cyc + w;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      logic eb;
      eb = (launch[k] <= cyc) && (cyc <= done_at[k]);
      chk((k == 0) ? "busy4" : "busy8", 32'(bsy[k]), 32'(eb));
      chk((k == 0) ? "done4" : "done8", 32'(dn[k]), 32'(cyc == done_at[k]));
      if (!eb || cyc == done_at[k]) begin
        chk((k == 0) ? "quot4" : "quot8", 32'(qo(k)), 32'(eq[k]));
        chk((k == 0) ? "rem4" : "rem8", 32'(ro(k)), 32'(er[k]));
        chk((k == 0) ? "dbz4" : "dbz8", 32'(dz[k]), 32'(ez[k]));
      end
    end
  end

  // Called at the negedge right after the start-sampling edge; n counts further edges until done.
  task automatic wait_done(input int k, output int n, output int bc);
    n = 0; bc = 0;
    while (dn[k] !== 1'b1 && n < 40) begin
      if (bsy[k]) bc++;
      @(negedge clock);
      n++;
    end
    if (bsy[k]) bc++;
    if (n >= 40) chk("done_timeout", 32'(n), 32'(0));
  endtask

  task automatic go(input int k, input logic [7:0] a, input logic [7:0] b,
                    output int n, output int bc);
    @(negedge clock);
    st[k] = 1'b1; dd[k] = a; dv[k] = b;
    @(negedge clock);
    st[k] = 1'b0; dd[k] = 8'($urandom); dv[k] = 8'($urandom);
    wait_done(k, n, bc);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, bc;
    st[0] = 0; st[1] = 0;
    dd[0] = 0; dd[1] = 0; dv[0] = 0; dv[1] = 0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_quot", 32'(q0), 0);
    chk("rst_dbz8", 32'(dz[1]), 0);
    reset = 1'b0;

    go(0, 13, 3, n, bc);
    chk("t1_latency", n, 4);
    chk("t1_busy_cycles", bc, 5);
    chk("t1_q", 32'(q0), 4);
    chk("t1_r", 32'(r0), 1);
    chk("t1_dbz", 32'(dz[0]), 0);

    go(0, 2, 7, n, bc);
    chk("t2a_q", 32'(q0), 0);
    chk("t2a_r", 32'(r0), 2);
    // Raised in the DONE cycle: the first edge must ignore it, the IDLE edge accepts.
    st[0] = 1'b1; dd[0] = 15; dv[0] = 1;
    @(negedge clock);
    chk("t2_done_start_ignored", 32'(bsy[0]), 0);
    @(negedge clock);
    st[0] = 1'b0;
    chk("t2_accepted", 32'(bsy[0]), 1);
    wait_done(0, n, bc);
    chk("t2b_latency", n, 4);
    chk("t2b_q", 32'(q0), 15);
    chk("t2b_r", 32'(r0), 0);

    go(0, 9, 0, n, bc);
    chk("t3_latency", n, 0);
    chk("t3_q", 32'(q0), 15);
    chk("t3_r", 32'(r0), 9);
    chk("t3_dbz", 32'(dz[0]), 1);
    go(0, 6, 2, n, bc);
    chk("t3b_q", 32'(q0), 3);
    chk("t3b_r", 32'(r0), 0);
    chk("t3b_dbz", 32'(dz[0]), 0);

    @(negedge clock);
    st[0] = 1'b1; dd[0] = 12; dv[0] = 5;
    @(negedge clock);
    st[0] = 1'b0;
    @(negedge clock);
    st[0] = 1'b1; dd[0] = 1; dv[0] = 1;
    @(negedge clock);
    st[0] = 1'b0;
    wait_done(0, n, bc);
    chk("t4_q", 32'(q0), 2);
    chk("t4_r", 32'(r0), 2);

    @(negedge clock);
    st[0] = 1'b1; dd[0] = 11; dv[0] = 3;
    @(negedge clock);
    st[0] = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t5_busy", 32'(bsy[0]), 0);
    chk("t5_done", 32'(dn[0]), 0);
    chk("t5_q", 32'(q0), 0);
    chk("t5_r", 32'(r0), 0);
    chk("t5_dbz", 32'(dz[0]), 0);
    @(negedge clock);
    reset = 1'b0;
    go(0, 7, 2, n, bc);
    chk("t5b_q", 32'(q0), 3);
    chk("t5b_r", 32'(r0), 1);

    go(1, 200, 7, n, bc);
    chk("t6_latency", n, 8);
    chk("t6_q", 32'(q1), 28);
    chk("t6_r", 32'(r1), 4);
    go(1, 8'hFF, 8'hFF, n, bc);
    chk("t6_max_q", 32'(q1), 1);
    chk("t6_max_r", 32'(r1), 0);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h0 : 8'($urandom);
      go(1, a, b, n, bc);
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
